// File: rtl/ase_pkg.sv
// ---------------------------------------------------------------------------
// ase_pkg
//  Shared ASE definitions for the TX-side stream tooling: the CCI-P TX header
//  width, the write-fence request encoding and the header field that holds
//  the request type. It also holds the state type of the stream_tid_stamper
//  flush FSM.
//  `TX_META_TYPERANGE is a macro rather than a package item because it is
//  used as a part-select range. It is defined only if nothing else has
//  defined it already.
// ---------------------------------------------------------------------------
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 55:52
`endif

package ase_pkg;

  localparam int         CCIP_TX_HDR_WIDTH = 74;
  localparam logic [3:0] CCIP_TX1_WRFENCE  = 4'h4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    WAIT,
    DONE
  } stamper_state_t;

endpackage

// File: rtl/tid_stamp_fifo.sv
// ---------------------------------------------------------------------------
// tid_stamp_fifo
//  Synchronous first-word-fall-through FIFO that holds the {meta, tid} words
//  of stream_tid_stamper. The head word is driven on dout whenever the FIFO
//  is not empty. When the FIFO is empty, dout is zero, so the outputs are
//  clean straight out of reset.
//  Parameters: WIDTH = word width, DEPTH = number of entries (power of 2, >=2).
//  Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, din       write a word (ignored when full)
//   pop             drop the head word (ignored when empty)
//   dout            head word (zero when empty)
//   full, empty     status from the registered occupancy
//   count           registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module tid_stamp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge, whatever order the
  // always_ff blocks run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of 2, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset. The pointers
  // and count define which entries are valid, and dout is forced to zero
  // while the FIFO is empty, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/stream_tid_stamper.sv
// ---------------------------------------------------------------------------
// stream_tid_stamper
//  Tags each CCI-P TX request that enters the latency/shuffle path with a
//  transaction ID and emits {meta, tid} pairs one cycle later through a FWFT
//  FIFO. Requests are throttled by an outstanding-credit limit, and credits
//  are released by retire_valid. A flush FSM (RUN/DRAIN/WAIT/DONE) quiesces
//  the stream: it stops intake, drains the FIFO, waits for every credit to
//  return, and then pulses flush_done for one cycle.
//  Configuration macro: STAMPER_FENCE_TID_EN. When it is defined, write
//  fences take a tid and a credit like any other request. When it is not
//  defined, a fence is stamped with tid 0 and does not touch the tid counter
//  or the credit count.
//  Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid_in, meta_in request in; in_ready = request accepted this cycle
//   valid_out, meta_out, tid_out, out_ready   tagged request out
//   retire_valid      one tagged request has returned
//   outstanding_cnt   credits in use
//   flush_req         start a flush (level, sampled in RUN)
//   flush_done        one-cycle pulse when the flush has completed
//   retire_underflow  sticky: a retire arrived with zero credits in use
// ---------------------------------------------------------------------------
module stream_tid_stamper
  import ase_pkg::*;
#(
  parameter int HDR_WIDTH       = CCIP_TX_HDR_WIDTH,
  parameter int TID_WIDTH       = 32,
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   valid_in,
  input  logic [HDR_WIDTH-1:0]                   meta_in,
  output logic                                   in_ready,
  output logic                                   valid_out,
  output logic [HDR_WIDTH-1:0]                   meta_out,
  output logic [TID_WIDTH-1:0]                   tid_out,
  input  logic                                   out_ready,
  input  logic                                   retire_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_cnt,
  input  logic                                   flush_req,
  output logic                                   flush_done,
  output logic                                   retire_underflow
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int FW    = HDR_WIDTH + TID_WIDTH;

  stamper_state_t             state;
  stamper_state_t             state_next;
  logic [TID_WIDTH-1:0]       tid_cnt;
  logic [CNT_W-1:0]           cnt_next;
  logic                       accept;
  logic                       counted;
  logic                       inc;
  logic [TID_WIDTH-1:0]       stamp_tid;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic [FW-1:0]              fifo_dout;

`ifdef STAMPER_FENCE_TID_EN
  assign counted = 1'b1;
`else
  // Fences are invisible to the checker, so they carry tid 0 and no credit.
  assign counted = (meta_in[`TX_META_TYPERANGE] != CCIP_TX1_WRFENCE);
`endif

  // in_ready depends only on registered state (and rst), never on valid_in.
  assign in_ready  = ~rst & (state == RUN) & ~fifo_full &
                     (outstanding_cnt < CNT_W'(MAX_OUTSTANDING));
  assign accept    = valid_in & in_ready;
  assign inc       = accept & counted;
  assign stamp_tid = counted ? tid_cnt : '0;
  assign valid_out = ~fifo_empty;

  tid_stamp_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   ({meta_in, stamp_tid}),
    .pop   (valid_out & out_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign meta_out = fifo_dout[FW-1:TID_WIDTH];
  assign tid_out  = fifo_dout[TID_WIDTH-1:0];

  // A credit taken and a credit returned in the same cycle cancel out.
  // A retire with nothing outstanding leaves the count at zero.
  always_comb begin
    cnt_next = outstanding_cnt;
    if (inc && !retire_valid)
      cnt_next = outstanding_cnt + 1'b1;
    else if (!inc && retire_valid && (outstanding_cnt != '0))
      cnt_next = outstanding_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tid_cnt          <= '0;
      outstanding_cnt  <= '0;
      retire_underflow <= 1'b0;
    end else begin
      // The tid counter wraps from all-ones to zero and survives a flush.
      if (inc) tid_cnt <= tid_cnt + 1'b1;
      outstanding_cnt <= cnt_next;
      if (retire_valid && (outstanding_cnt == '0)) retire_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // NOTE: every signal assigned in this block gets a default first, so
  // paths that do not assign it cannot infer a latch.
  always_comb begin
    state_next = state;
    flush_done = 1'b0;
    case (state)
      RUN:   if (flush_req) state_next = DRAIN;
      DRAIN: begin
        if (fifo_count == '0)
          state_next = (outstanding_cnt != '0) ? WAIT : DONE;
      end
      // Include this cycle's retire so DONE follows the last return at once.
      WAIT:  if (cnt_next == '0) state_next = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_stream_tid_stamper.sv
// ---------------------------------------------------------------------------
// tb_stream_tid_stamper
//  Directed bench for stream_tid_stamper (DEPTH=8, MAX_OUTSTANDING=12).
//  A queue-based model of the stamping, credit and flush rules predicts every
//  output on every cycle. Hand-computed literals pin the key points of each
//  scenario.
// ---------------------------------------------------------------------------
module tb_stream_tid_stamper;

  localparam int HDR     = ase_pkg::CCIP_TX_HDR_WIDTH;
  localparam int TIDW    = 32;
  localparam int DEPTH   = 8;
  localparam int MAX_OUT = 12;
  localparam int CW      = $clog2(MAX_OUT+1);
`ifdef STAMPER_FENCE_TID_EN
  localparam bit FENCE_EN = 1'b1;
`else
  localparam bit FENCE_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_in = 1'b0;
  logic [HDR-1:0]  meta_in = '0;
  logic            in_ready;
  logic            valid_out;
  logic [HDR-1:0]  meta_out;
  logic [TIDW-1:0] tid_out;
  logic            out_ready = 1'b0;
  logic            retire_valid = 1'b0;
  logic [CW-1:0]   outstanding_cnt;
  logic            flush_req = 1'b0;
  logic            flush_done;
  logic            retire_underflow;

  always #5 clk = ~clk;

  stream_tid_stamper #(
    .HDR_WIDTH       (HDR),
    .TID_WIDTH       (TIDW),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .meta_in          (meta_in),
    .in_ready         (in_ready),
    .valid_out        (valid_out),
    .meta_out         (meta_out),
    .tid_out          (tid_out),
    .out_ready        (out_ready),
    .retire_valid     (retire_valid),
    .outstanding_cnt  (outstanding_cnt),
    .flush_req        (flush_req),
    .flush_done       (flush_done),
    .retire_underflow (retire_underflow)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [HDR-1:0]  meta;
    logic [TIDW-1:0] tid;
  } ent_t;
  typedef enum {M_RUN, M_DRAIN, M_WAIT, M_DONE} mphase_t;

  ent_t      q[$];
  int        m_cnt   = 0;
  logic [TIDW-1:0] m_tid = '0;
  bit        m_uf    = 1'b0;
  mphase_t   m_phase = M_RUN;
  bit        cmp_en  = 1'b0;
  logic [TIDW-1:0] obs[$];
  int        pop_count = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = 0; m_tid = '0; m_uf = 1'b0; m_phase = M_RUN;
    end else begin
      int      old_size;
      int      old_cnt;
      bit      ready, fence, counted, inc;
      ent_t    e;
      old_size = q.size();
      old_cnt  = m_cnt;
      ready    = (m_phase == M_RUN) && (old_size < DEPTH) && (old_cnt < MAX_OUT);
      if (old_size > 0 && out_ready) void'(q.pop_front());
      inc = 1'b0;
      if (valid_in && ready) begin
        fence   = (meta_in[`TX_META_TYPERANGE] == ase_pkg::CCIP_TX1_WRFENCE);
        counted = FENCE_EN || !fence;
        e.meta  = meta_in;
        e.tid   = counted ? m_tid : '0;
        q.push_back(e);
        if (counted) m_tid = m_tid + 1;
        inc = counted;
      end
      if (retire_valid && old_cnt == 0) m_uf = 1'b1;
      if (inc && !retire_valid)                    m_cnt = old_cnt + 1;
      else if (!inc && retire_valid && old_cnt > 0) m_cnt = old_cnt - 1;
      case (m_phase)
        M_RUN:   if (flush_req) m_phase = M_DRAIN;
        M_DRAIN: if (old_size == 0) m_phase = (old_cnt > 0) ? M_WAIT : M_DONE;
        M_WAIT:  if (m_cnt == 0) m_phase = M_DONE;
        M_DONE:  m_phase = M_RUN;
      endcase
    end
  end

  // Compare process: every cycle, 2 time units after the input-driving edge.
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      check("valid_out", valid_out, q.size() > 0);
      if (q.size() > 0) begin
        check("tid_out", tid_out, q[0].tid);
        check("meta_out", meta_out, q[0].meta);
        if (out_ready) begin
          obs.push_back(tid_out);
          pop_count++;
        end
      end
      check("outstanding_cnt", outstanding_cnt, m_cnt);
      check("in_ready", in_ready,
            !rst && m_phase == M_RUN && q.size() < DEPTH && m_cnt < MAX_OUT);
      check("flush_done", flush_done, m_phase == M_DONE);
      check("retire_underflow", retire_underflow, m_uf);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [HDR-1:0] mk(input int i, input bit fence);
    logic [HDR-1:0] m;
    m = '0;
    m[31:0] = 32'hA5A5_0000 ^ i;
    m[HDR-1:HDR-8] = 8'(i * 7 + 3);
    m[`TX_META_TYPERANGE] = fence ? ase_pkg::CCIP_TX1_WRFENCE : 4'h1;
    return m;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Call at a negedge; returns at the negedge after the request is accepted.
  task automatic push(input logic [HDR-1:0] m);
    bit done = 1'b0;
    bit rdy;
    valid_in = 1'b1;
    meta_in  = m;
    for (int k = 0; k < 60 && !done; k++) begin
      #2;
      rdy = in_ready;
      @(negedge clk);
      if (rdy) done = 1'b1;
    end
    valid_in = 1'b0;
    check("push_accepted", done, 1'b1);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; valid_in = 1'b0; retire_valid = 1'b0; flush_req = 1'b0;
    step();
    rst = 1'b0;
    obs.delete();
    pop_count = 0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && valid_out; k++) step();
    check("drain_bounded", valid_out, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---- 1: reset state, then three back-to-back requests ----
    out_ready = 1'b1;
    repeat (2) step();
    cmp_en = 1'b1;
    #3;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_tid_out", tid_out, 0);
    check("rst_meta_out", meta_out, 0);
    check("rst_cnt", outstanding_cnt, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) begin valid_in = 1'b1; meta_in = mk(i, 1'b0); end
      else valid_in = 1'b0;
      if (i > 0) begin #3; check("t1_tid", tid_out, i - 1); end
    end
    check("t1_cnt", outstanding_cnt, 3);

    // ---- 2: FIFO full with out_ready low, then drain in order ----
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(mk(i, 1'b0));
    valid_in = 1'b1; meta_in = mk(8, 1'b0);
    #3;
    check("t2_full_ready", in_ready, 1'b0);
    check("t2_hold_tid", tid_out, 0);
    repeat (2) step();
    #3;
    check("t2_hold_meta", meta_out, mk(0, 1'b0));
    step();
    out_ready = 1'b1;
    push(mk(8, 1'b0));
    wait_drain();
    check("t2_pops", pop_count, 9);
    for (int i = 0; i < 9; i++) check("t2_order", (i < obs.size()) ? obs[i] : 32'hDEAD, i);

    // ---- 3: credit limit ----
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < MAX_OUT; i++) push(mk(i, 1'b0));
    valid_in = 1'b1; meta_in = mk(50, 1'b0);
    #3;
    check("t3_stall_ready", in_ready, 1'b0);
    check("t3_stall_cnt", outstanding_cnt, MAX_OUT);
    step();
    retire_valid = 1'b1;
    step();
    retire_valid = 1'b0;
    #3;
    check("t3_ready_after_retire", in_ready, 1'b1);
    step();
    valid_in = 1'b0; retire_valid = 1'b1;
    #3;
    check("t3_cnt_refilled", outstanding_cnt, MAX_OUT);
    step();
    valid_in = 1'b1; meta_in = mk(51, 1'b0); retire_valid = 1'b1;
    step();
    valid_in = 1'b0; retire_valid = 1'b0;
    #3;
    check("t3_acc_ret_cnt", outstanding_cnt, MAX_OUT - 1);

    // ---- 4: fence between tids 5 and 6 ----
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(mk(i, 1'b0));
    push(mk(6, 1'b1));
    push(mk(7, 1'b0));
    wait_drain();
    check("t4_fence_tid", (obs.size() > 6) ? obs[6] : 32'hDEAD, FENCE_EN ? 6 : 0);
    check("t4_next_tid", (obs.size() > 7) ? obs[7] : 32'hDEAD, FENCE_EN ? 7 : 6);
    check("t4_cnt", outstanding_cnt, FENCE_EN ? 8 : 7);

    // ---- 5: tid wrap ----
    do_reset();
    out_ready = 1'b1;
    step();
    force dut.tid_cnt = 32'hFFFF_FFFF;
    m_tid = 32'hFFFF_FFFF;
    #1 release dut.tid_cnt;
    step();
    push(mk(1, 1'b0));
    push(mk(2, 1'b0));
    wait_drain();
    check("t5_tid_max", (obs.size() > 0) ? obs[0] : 32'hDEAD, 32'hFFFF_FFFF);
    check("t5_tid_wrap", (obs.size() > 1) ? obs[1] : 32'hDEAD, 32'h0);

    // ---- 6: flush with 2 in FIFO, 5 outstanding ----
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(mk(i, 1'b0));
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    #3;
    check("t6_drain_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    repeat (4) step();
    #3;
    check("t6_wait_cnt", outstanding_cnt, 5);
    check("t6_wait_no_done", flush_done, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      retire_valid = 1'b1;
    end
    step();
    retire_valid = 1'b0;
    #3;
    check("t6_flush_done", flush_done, 1'b1);
    step();
    #3;
    check("t6_done_pulse_end", flush_done, 1'b0);
    check("t6_run_ready", in_ready, 1'b1);
    retire_valid = 1'b1;
    step();
    retire_valid = 1'b0;
    repeat (3) step();
    #3;
    check("t6_underflow", retire_underflow, 1'b1);
    check("t6_underflow_cnt", outstanding_cnt, 0);
    do_reset();
    #3;
    check("t6_underflow_cleared", retire_underflow, 1'b0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
